// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: arbitrates two write requesters into a paced
// setup/strobe/hold sequence. Define FB_CLEAR_EN to include the clear engine.
module fb_write_sched #(
    parameter int          SETUP_CYC   = 1,
    parameter int          HOLD_CYC    = 1,
    parameter logic [11:0] CLEAR_VALUE = 12'h000
) (
    input  logic        clk_cpu_fast,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [11:0] a_addr,
    input  logic [11:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [11:0] b_addr,
    input  logic [11:0] b_data,
    output logic        b_ready,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic [11:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        fb_we,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] fb_addr_q, fb_addr_d;
    logic [11:0] fb_data_q, fb_data_d;
    logic        fb_we_q, fb_we_d;
    logic        busy_q, busy_d;
    logic        rdy_en_q, rdy_en_d;
    logic        last_b_q, last_b_d;
    logic        clear_busy_q, clear_busy_d;
    logic [11:0] clr_addr_q, clr_addr_d;
    logic        clr_wr_q, clr_wr_d;
    logic        clear_req;
    logic        sel_a;
    logic        ready_en;

`ifdef FB_CLEAR_EN
    assign clear_req = clear_start;
`else
    logic unused_clear;
    assign clear_req    = 1'b0;
    assign unused_clear = clear_start;
`endif

    // Round-robin pick; with no valid pending the non-last requester is offered.
    assign sel_a    = a_valid ? (!b_valid || last_b_q) : (!b_valid && last_b_q);
    // rdy_en_q is a flop so ready stays low through reset and the first cycle after.
    assign ready_en = rdy_en_q && !clear_busy_q && !clear_req;
    assign a_ready  = ready_en && sel_a;
    assign b_ready  = ready_en && !sel_a;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_we_d      = 1'b0;
        last_b_d     = last_b_q;
        clear_busy_d = clear_busy_q;
        clr_addr_d   = clr_addr_q;
        clr_wr_d     = clr_wr_q;
        case (state_q)
            S_IDLE: begin
                if (clear_busy_q) begin
                    state_d    = S_SETUP;
                    cnt_d      = 4'd0;
                    fb_addr_d  = clr_addr_q;
                    fb_data_d  = CLEAR_VALUE;
                    clr_addr_d = clr_addr_q + 12'd1;
                    clr_wr_d   = 1'b1;
                end else if (a_valid && a_ready) begin
                    state_d   = S_SETUP;
                    cnt_d     = 4'd0;
                    fb_addr_d = a_addr;
                    fb_data_d = a_data;
                    last_b_d  = 1'b0;
                end else if (b_valid && b_ready) begin
                    state_d   = S_SETUP;
                    cnt_d     = 4'd0;
                    fb_addr_d = b_addr;
                    fb_data_d = b_data;
                    last_b_d  = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = 4'd0;
                    fb_we_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_STROBE: begin
                state_d = S_HOLD;
                cnt_d   = 4'd0;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d  = S_IDLE;
                    cnt_d    = 4'd0;
                    clr_wr_d = 1'b0;
                    // The clear finishes when the write to the top address leaves HOLD.
                    if (clr_wr_q && fb_addr_q == 12'hFFF) begin
                        clear_busy_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_req && !clear_busy_q) begin
            clear_busy_d = 1'b1;
            clr_addr_d   = 12'd0;
        end
    end

    assign busy_d   = (state_d != S_IDLE);
    assign rdy_en_d = (state_d == S_IDLE);

    always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            fb_addr_q    <= 12'd0;
            fb_data_q    <= 12'd0;
            fb_we_q      <= 1'b0;
            busy_q       <= 1'b0;
            rdy_en_q     <= 1'b0;
            last_b_q     <= 1'b1;
            clear_busy_q <= 1'b0;
            clr_addr_q   <= 12'd0;
            clr_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            busy_q       <= busy_d;
            rdy_en_q     <= rdy_en_d;
            last_b_q     <= last_b_d;
            clear_busy_q <= clear_busy_d;
            clr_addr_q   <= clr_addr_d;
            clr_wr_q     <= clr_wr_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign busy       = busy_q;
    assign clear_busy = clear_busy_q;
endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched: transaction-level reference model for the default
// instance, directed timing for a SETUP_CYC=3/HOLD_CYC=2 instance.
module tb_fb_write_sched;
    localparam int S = 1;
    localparam int H = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, clear_start = 1'b0;
    logic [11:0] a_addr = '0, a_data = '0, b_addr = '0, b_data = '0;
    logic        a_ready, b_ready, clear_busy, fb_we, busy;
    logic [11:0] fb_addr, fb_data;

    logic        a2_valid = 1'b0, b2_valid = 1'b0, clear2_start = 1'b0;
    logic [11:0] a2_addr = '0, a2_data = '0, b2_addr = '0, b2_data = '0;
    logic        a2_ready, b2_ready, clear2_busy, fb2_we, busy2;
    logic [11:0] fb2_addr, fb2_data;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle-indexed schedule of the next free slot and strobe.
    int          cyc = 0, idle_at = 0, busy_from = 0, we_at = -100;
    bit          last_b = 1'b1;
    logic [11:0] exp_addr = '0, exp_data = '0;

    always #5 clk = ~clk;

    fb_write_sched dut (
        .clk_cpu_fast(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .busy(busy)
    );

    fb_write_sched #(.SETUP_CYC(3), .HOLD_CYC(2)) dut2 (
        .clk_cpu_fast(clk), .rst_n(rst_n),
        .a_valid(a2_valid), .a_addr(a2_addr), .a_data(a2_data), .a_ready(a2_ready),
        .b_valid(b2_valid), .b_addr(b2_addr), .b_data(b2_data), .b_ready(b2_ready),
        .clear_start(clear2_start), .clear_busy(clear2_busy),
        .fb_addr(fb2_addr), .fb_data(fb2_data), .fb_we(fb2_we), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idle_at   = cyc + 1;
        busy_from = idle_at;
        we_at     = -100;
        exp_addr  = '0;
        exp_data  = '0;
        last_b    = 1'b1;
    endtask

    // One clock on the default instance, checked against the model.
    task automatic tick();
        bit rdy, pick_b, hs;
        #1;
        rdy = (cyc >= idle_at);
        if (a_valid && b_valid) pick_b = !last_b;
        else if (a_valid)       pick_b = 1'b0;
        else if (b_valid)       pick_b = 1'b1;
        else                    pick_b = !last_b;
        chk("a_ready", 32'(a_ready), 32'(rdy && !pick_b));
        chk("b_ready", 32'(b_ready), 32'(rdy && pick_b));
        hs = rdy && (pick_b ? b_valid : a_valid);
        if (hs) begin
            exp_addr  = pick_b ? b_addr : a_addr;
            exp_data  = pick_b ? b_data : a_data;
            busy_from = cyc + 1;
            we_at     = cyc + 1 + S;
            idle_at   = cyc + 2 + S + H;
            last_b    = pick_b;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("fb_we", 32'(fb_we), 32'(cyc == we_at));
        chk("fb_addr", 32'(fb_addr), 32'(exp_addr));
        chk("fb_data", 32'(fb_data), 32'(exp_data));
        chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < idle_at));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int n, guard;
        // Reset with both requesters pending: nothing may be offered.
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Single A write 0x123/0xABC.
        a_valid = 1'b1; a_addr = 12'h123; a_data = 12'hABC;
        tick();
        tick();
        a_valid = 1'b0; a_addr = 12'hFFF; a_data = 12'h555;
        repeat (5) tick();

        // Both valid continuously: grants must alternate.
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_addr = 12'($urandom); a_data = 12'($urandom);
            b_addr = 12'($urandom); b_data = 12'($urandom);
            tick();
        end

        // Random valids that may drop before being served.
        for (int i = 0; i < 400; i++) begin
            a_valid = ($urandom_range(0, 2) != 0);
            b_valid = ($urandom_range(0, 2) != 0);
            a_addr = 12'($urandom); a_data = 12'($urandom);
            b_addr = 12'($urandom); b_data = 12'($urandom);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (5) tick();

        // Reset asserted while the strobe is high.
        a_valid = 1'b1; a_addr = 12'h3C3; a_data = 12'h5A5;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (fb_we === 1'b1) found = 1'b1;
        end
        chk("strobe_reached", 32'(found), 32'd1);
        a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_fb_we", 32'(fb_we), 32'd0);
        chk("rstw_fb_addr", 32'(fb_addr), 32'd0);
        chk("rstw_fb_data", 32'(fb_data), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        model_reset();
        repeat (6) tick();

`ifdef FB_CLEAR_EN
        a_valid = 1'b1; a_addr = 12'h777; a_data = 12'h111;
        clear_start = 1'b1;
        #1;
        chk("clr_start_a_ready", 32'(a_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clear_start = 1'b0;
        n = 0; guard = 0;
        while (clear_busy === 1'b1 && guard < 20000) begin
            if (fb_we === 1'b1) begin
                chk("clr_addr", 32'(fb_addr), 32'(n));
                chk("clr_data", 32'(fb_data), 32'h000);
                n++;
            end
            #1;
            chk("clr_a_ready", 32'(a_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        chk("clr_finished", 32'(guard < 20000), 32'd1);
        chk("clr_count", 32'(n), 32'd4096);
        #1;
        chk("clr_then_a_ready", 32'(a_ready), 32'd1);
        a_valid = 1'b0;
`else
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("noclr_busy", 32'(clear_busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("noclr_busy", 32'(clear_busy), 32'd0);
        end
`endif

        // SETUP_CYC=3, HOLD_CYC=2: strobe at N+4, next handshake at N+7.
        @(negedge clk);
        a2_valid = 1'b1; a2_addr = 12'h2A1; a2_data = 12'h0F0;
        #1;
        chk("p_ready_n0", 32'(a2_ready), 32'd1);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                a2_addr = 12'h4B2; a2_data = 12'hE1E;
            end
            chk("p_fb_we", 32'(fb2_we), 32'((k == 4) || (k == 11)));
            if (k == 1) chk("p_addr1", 32'(fb2_addr), 32'h2A1);
            if (k == 1) chk("p_data1", 32'(fb2_data), 32'h0F0);
            if (k == 8) chk("p_addr2", 32'(fb2_addr), 32'h4B2);
            #1;
            if (k == 6) chk("p_ready_n6", 32'(a2_ready), 32'd0);
            if (k == 7) chk("p_ready_n7", 32'(a2_ready), 32'd1);
        end
        a2_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
